// File: rtl/rgb_2_bw_final.sv
// -----------------------------------------------------------------------------
// rgb_2_bw_final
//
// Purpose:
//   Two-stage pipelined RGB-to-grayscale converter. One 8-bit R/G/B pixel is
//   accepted per clock. The block produces the unnormalised weighted luminance
//   sum W_R*R + W_G*G + W_B*B and a thresholded black/white bit.
//
//   Stage 1 registers the three channel products, the threshold scaled into
//   sum units (threshold * (W_R+W_G+W_B)) and the valid bit.
//   Stage 2 registers the sum, the threshold compare result and the valid bit.
//   Latency is exactly 2 clocks. Throughput is 1 pixel/clock with no
//   backpressure.
//
// Handshake:
//   in_valid qualifies origi_* and bw_threshold in the cycle where it is
//   sampled. out_valid qualifies intmod_red, bw_pixel (and gray8) exactly two
//   clocks later. There is no ready signal, so the consumer must accept every
//   out_valid beat. Data registers load every cycle. While out_valid is 0 the
//   data outputs carry pipelined junk that consumers ignore.
//
// Optional feature (macro GRAY8_OUT_EN):
//   When the macro is defined, the block adds the output gray8 =
//   floor(intmod_red*41/4096), which approximates intmod_red/100. It is only
//   meaningful with the default weights.
//
// Ports:
//   clk           in   1      system clock, rising edge
//   rst_n         in   1      asynchronous active-low reset
//   in_valid      in   1      qualifies origi_* / bw_threshold
//   origi_red     in   8      red component, unsigned
//   origi_green   in   8      green component, unsigned
//   origi_blue    in   8      blue component, unsigned
//   bw_threshold  in   8      B/W threshold in gray units (0..255)
//   out_valid     out  1      qualifies intmod_red / bw_pixel
//   intmod_red    out  OUT_W  weighted sum W_R*R + W_G*G + W_B*B
//   bw_pixel      out  1      1 = white (sum >= threshold*weights), 0 = black
//   gray8         out  8      (GRAY8_OUT_EN only) approx intmod_red/100
//
// Parameters:
//   W_R, W_G, W_B  channel weights. Their sum must be <= 128 so that
//                  255*(W_R+W_G+W_B) fits in OUT_W.
//   OUT_W          width of the sum bus
// -----------------------------------------------------------------------------
module rgb_2_bw_final #(
  parameter int unsigned W_R   = 30,
  parameter int unsigned W_G   = 59,
  parameter int unsigned W_B   = 11,
  parameter int unsigned OUT_W = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [7:0]       origi_red,
  input  logic [7:0]       origi_green,
  input  logic [7:0]       origi_blue,
  input  logic [7:0]       bw_threshold,
  output logic             out_valid,
  output logic [OUT_W-1:0] intmod_red,
`ifdef GRAY8_OUT_EN
  output logic [7:0]       gray8,
`endif
  output logic             bw_pixel
);

  localparam int unsigned W_SUM = W_R + W_G + W_B;
  // Width needed for the intmod_red*41 product used by gray8.
  localparam int unsigned GW    = OUT_W + 6;

  // Stage-1 products. Each product is at most 255*W_SUM, and that bound fits
  // in OUT_W, so the truncation to OUT_W bits is exact.
  logic [OUT_W-1:0] w_pr;
  logic [OUT_W-1:0] w_pg;
  logic [OUT_W-1:0] w_pb;
  logic [OUT_W-1:0] w_thr;

  assign w_pr  = OUT_W'(W_R)   * OUT_W'(origi_red);
  assign w_pg  = OUT_W'(W_G)   * OUT_W'(origi_green);
  assign w_pb  = OUT_W'(W_B)   * OUT_W'(origi_blue);
  // Scaling the threshold into sum units lets stage 2 compare directly
  // against the sum. No divider is needed.
  assign w_thr = OUT_W'(W_SUM) * OUT_W'(bw_threshold);

  logic             r_valid1;
  logic [OUT_W-1:0] r_pr;
  logic [OUT_W-1:0] r_pg;
  logic [OUT_W-1:0] r_pb;
  logic [OUT_W-1:0] r_thr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid1 <= 1'b0;
      r_pr     <= '0;
      r_pg     <= '0;
      r_pb     <= '0;
      r_thr    <= '0;
    end else begin
      r_valid1 <= in_valid;
      r_pr     <= w_pr;
      r_pg     <= w_pg;
      r_pb     <= w_pb;
      r_thr    <= w_thr;
    end
  end

  // Stage-2 sum. It cannot overflow for the same reason the products cannot.
  logic [OUT_W-1:0] w_sum;
  assign w_sum = r_pr + r_pg + r_pb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      intmod_red <= '0;
      bw_pixel   <= 1'b0;
    end else begin
      out_valid  <= r_valid1;
      intmod_red <= w_sum;
      bw_pixel   <= (w_sum >= r_thr);
    end
  end

`ifdef GRAY8_OUT_EN
  // 41/4096 ~= 1/100. The result stays <= 255 for sums up to 25500.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gray8 <= 8'd0;
    end else begin
      gray8 <= 8'((GW'(w_sum) * GW'(41)) >> 12);
    end
  end
`endif

endmodule

// File: tb/tb_rgb_2_bw_final.sv
// -----------------------------------------------------------------------------
// tb_rgb_2_bw_final
//
// Scoreboard bench for rgb_2_bw_final with the default weights (30/59/11).
// The driver pushes each expected response together with the cycle in which
// it must appear. A negedge monitor pops and compares the value and the
// timing of every out_valid beat.
// -----------------------------------------------------------------------------
module tb_rgb_2_bw_final;

  localparam int OUT_W = 15;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic [7:0]       origi_red = '0;
  logic [7:0]       origi_green = '0;
  logic [7:0]       origi_blue = '0;
  logic [7:0]       bw_threshold = '0;
  logic             out_valid;
  logic [OUT_W-1:0] intmod_red;
  logic             bw_pixel;
`ifdef GRAY8_OUT_EN
  logic [7:0]       gray8;
`endif

  rgb_2_bw_final dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .origi_red    (origi_red),
    .origi_green  (origi_green),
    .origi_blue   (origi_blue),
    .bw_threshold (bw_threshold),
    .out_valid    (out_valid),
    .intmod_red   (intmod_red),
`ifdef GRAY8_OUT_EN
    .gray8        (gray8),
`endif
    .bw_pixel     (bw_pixel)
  );

  // ---------------- clock / reset / cycle counter ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- scoreboard state ----------------
  // Each entry packs {gray8, bw, sum[14:0]}.
  logic [23:0] exp_q[$];
  int          exp_cyc_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [23:0] pk(input int g8, input int bw, input int s);
    logic [7:0]  g;
    logic [14:0] sv;
    g  = 8'(g8);
    sv = 15'(s);
    return {g, bw[0], sv};
  endfunction

  // Reference model: luminance formula with the threshold scaled to sum units.
  function automatic logic [23:0] model(input int r, input int g, input int b, input int thr);
    int s;
    s = 30 * r + 59 * g + 11 * b;
    return pk(s * 41 / 4096, (s >= thr * 100) ? 1 : 0, s);
  endfunction

  // ---------------- driver tasks ----------------
  // Inputs change 1ns after a rising edge and are sampled by the next edge.
  // The result is registered one edge after that, i.e. at cyc+2.
  task automatic send(input int r, input int g, input int b, input int thr,
                      input logic [23:0] e);
    @(posedge clk);
    #1;
    in_valid     = 1'b1;
    origi_red    = 8'(r);
    origi_green  = 8'(g);
    origi_blue   = 8'(b);
    bw_threshold = 8'(thr);
    exp_q.push_back(e);
    exp_cyc_q.push_back(cyc + 2);
  endtask

  task automatic send_model(input int r, input int g, input int b, input int thr);
    send(r, g, b, thr, model(r, g, b, thr));
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    in_valid     = 1'b0;
    origi_red    = 8'($urandom_range(0, 255));
    origi_green  = 8'($urandom_range(0, 255));
    origi_blue   = 8'($urandom_range(0, 255));
    bw_threshold = 8'($urandom_range(0, 255));
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", 1, 0);
      end else begin
        logic [23:0] e;
        int          ec;
        e  = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        check("latency_cycle", cyc, ec);
        check("intmod_red", int'(intmod_red), int'(e[14:0]));
        check("bw_pixel", int'(bw_pixel), int'(e[15]));
`ifdef GRAY8_OUT_EN
        check("gray8", int'(gray8), int'(e[23:16]));
`endif
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int thr;
    // Hold reset while the inputs toggle. The outputs must stay cleared.
    rst_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      in_valid     = 1'($urandom_range(0, 1));
      origi_red    = 8'($urandom_range(0, 255));
      origi_green  = 8'($urandom_range(0, 255));
      origi_blue   = 8'($urandom_range(0, 255));
      bw_threshold = 8'($urandom_range(0, 255));
      @(negedge clk);
      check("reset_out_valid", int'(out_valid), 0);
      check("reset_intmod_red", int'(intmod_red), 0);
      check("reset_bw_pixel", int'(bw_pixel), 0);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst_n    = 1'b1;
    idle();

    // Primaries at threshold 128 (12800 in sum units).
    send(255, 0, 0, 128, pk(76, 0, 7650));
    send(0, 255, 0, 128, pk(150, 1, 15045));
    send(0, 0, 255, 128, pk(28, 0, 2805));
    idle();
    idle();

    // Extremes and threshold boundaries.
    send(0, 0, 0, 1, pk(0, 0, 0));
    send(0, 0, 0, 0, pk(0, 1, 0));
    send(255, 255, 255, 255, pk(255, 1, 25500));
    send(254, 255, 255, 255, pk(254, 0, 25470));
    idle();

    // Mixed back-to-back streaming.
    send(10, 20, 30, 128, pk(18, 0, 1810));
    send(100, 150, 200, 128, pk(140, 1, 14050));
    send(1, 1, 1, 0, pk(1, 1, 100));
    idle();
    idle();
    idle();

    // Reset mid-stream: two pixels in flight, then a half-cycle reset pulse.
    send_model(200, 100, 50, 64);
    send_model(20, 40, 60, 10);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check("async_reset_out_valid", int'(out_valid), 0);
    check("async_reset_intmod_red", int'(intmod_red), 0);
    check("async_reset_bw_pixel", int'(bw_pixel), 0);
    void'(exp_q.pop_back());
    void'(exp_q.pop_back());
    void'(exp_cyc_q.pop_back());
    void'(exp_cyc_q.pop_back());
    #3;
    rst_n = 1'b1;
    send(0, 255, 0, 128, pk(150, 1, 15045));
    idle();
    idle();
    idle();

    // Random stream with random bubbles and biased thresholds.
    for (int i = 0; i < 16384; i++) begin
      if ($urandom_range(0, 3) == 0) idle();
      case ($urandom_range(0, 7))
        0:       thr = 0;
        1:       thr = 255;
        default: thr = $urandom_range(0, 255);
      endcase
      send_model($urandom_range(0, 255), $urandom_range(0, 255),
                 $urandom_range(0, 255), thr);
    end
    idle();

    // Drain with a bounded wait.
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
